// File: rtl/div_sched_pkg.sv
// Shared definitions for the divide sequencer: FSM state encodings,
// RV32M divide funct3 codes and the default iteration count.
package div_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam int unsigned DIV_STEPS_DEF = 32;

  // Two's-complement magnitude when take_abs is set and the value is negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic take_abs);
    return (take_abs && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// Bundle of the EX-side request and the write-back/redirect result signals.
// master: the pipeline side driving requests; slave: the divide sequencer.
interface div_sched_if;

  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] inst_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, inst_addr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_we_o, reg_waddr_o, jump_flag_o, jump_addr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, inst_addr_i, flush_i,
    output busy_o, ready_o, result_o, reg_we_o, reg_waddr_o, jump_flag_o, jump_addr_o
  );

endinterface

// File: rtl/div_sched_step.sv
// div_step: one combinational restoring-division iteration.
// The dividend is shifted in through quo; rem accumulates the partial remainder.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Shift {rem, quo} left and trial-subtract; bit W of diff is the borrow.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_next = diff[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: multi-cycle RV32M divide/remainder sequencer with deferred
// write-back and PC+4 redirect. Optional macro DIV_FAST_SPECIAL_EN sends
// divide-by-zero and signed overflow straight from IDLE to DONE.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned DIV_STEPS = DIV_STEPS_DEF
) (
  input logic       clk,
  input logic       rst,
  div_sched_if.slave bus
);

  localparam int unsigned CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_rem_q, neg_q, neg_r, div0_q, ovf_q;
  logic [31:0]   rem_q, quo_q, dvs_q, dvd_q, jaddr_q;
  logic [4:0]    waddr_q;
  logic [31:0]   res_hold, jaddr_hold;
  logic [4:0]    waddr_hold;
  logic [31:0]   rem_nx, quo_nx;
  logic [31:0]   q_fix, r_fix, fin_res;
  logic          start_ok, op_signed, div0_in, ovf_in, go_fast, done_fire;

  div_step #(.W(32)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Request decode: flush beats start, special operands flagged at issue.
  always_comb begin
    start_ok  = bus.start_i & ~bus.flush_i;
    op_signed = (bus.op_i == INST_DIV) | (bus.op_i == INST_REM);
    div0_in   = (bus.divisor_i == '0);
    ovf_in    = op_signed & (bus.dividend_i == 32'h8000_0000) & (bus.divisor_i == '1);
`ifdef DIV_FAST_SPECIAL_EN
    go_fast   = div0_in | ovf_in;
`else
    go_fast   = 1'b0;
`endif
  end

  // Sequencer FSM, operand capture and held output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      is_rem_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      jaddr_q    <= '0;
      waddr_q    <= '0;
      res_hold   <= '0;
      jaddr_hold <= '0;
      waddr_hold <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            is_rem_q <= bus.op_i[1];
            waddr_q  <= bus.reg_waddr_i;
            jaddr_q  <= bus.inst_addr_i + 32'd4;
            dvd_q    <= bus.dividend_i;
            dvs_q    <= mag32(bus.divisor_i, op_signed);
            quo_q    <= mag32(bus.dividend_i, op_signed);
            rem_q    <= '0;
            cnt      <= '0;
            neg_q    <= op_signed & (bus.dividend_i[31] ^ bus.divisor_i[31]);
            neg_r    <= op_signed & bus.dividend_i[31];
            div0_q   <= div0_in;
            ovf_q    <= ovf_in;
            state    <= go_fast ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt == LAST) state <= S_DONE;
            else             cnt   <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!bus.flush_i) begin
            res_hold   <= fin_res;
            waddr_hold <= waddr_q;
            jaddr_hold <= jaddr_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign fix, then special-case override (div-by-zero, signed overflow).
  always_comb begin
    q_fix = neg_q ? (~quo_q + 32'd1) : quo_q;
    r_fix = neg_r ? (~rem_q + 32'd1) : rem_q;
    if (div0_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = 32'h8000_0000;
      r_fix = '0;
    end
    fin_res = is_rem_q ? r_fix : q_fix;
  end

  // Outputs: pulses only in an unflushed DONE cycle; data holds otherwise.
  always_comb begin
    done_fire       = (state == S_DONE) & ~bus.flush_i;
    bus.busy_o      = (state != S_IDLE) | start_ok;
    bus.ready_o     = done_fire;
    bus.reg_we_o    = done_fire;
    bus.jump_flag_o = done_fire;
    bus.result_o    = done_fire ? fin_res : res_hold;
    bus.reg_waddr_o = done_fire ? waddr_q : waddr_hold;
    bus.jump_addr_o = done_fire ? jaddr_q : jaddr_hold;
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed testbench for div_sched; honours DIV_FAST_SPECIAL_EN for
// special-case latency.
module tb_div_sched;
  import div_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  always #5 clk = ~clk;

  div_sched_if bus();

  div_sched #(.DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] r_res, r_ja;
  logic [4:0]  r_wa;
  logic        r_we, r_jf, r_bs, r_ba;
  int          r_lat, r_pul;

  // Issue one op and observe 40 cycles: first ready latency, captured outputs,
  // pulse count, busy in the start cycle and in the cycle after ready.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] pc);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b;
    bus.reg_waddr_i = rd; bus.inst_addr_i = pc;
    #1 r_bs = bus.busy_o;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    r_lat = -1; r_pul = 0; r_ba = 1'b1;
    r_res = 'x; r_wa = 'x; r_ja = 'x; r_we = 1'b0; r_jf = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        r_pul++;
        if (r_lat < 0) begin
          r_lat = k; r_res = bus.result_o; r_wa = bus.reg_waddr_o;
          r_ja = bus.jump_addr_o; r_we = bus.reg_we_o; r_jf = bus.jump_flag_o;
        end
      end
      if (r_lat > 0 && k == r_lat + 1) r_ba = bus.busy_o;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.ready_o, bus.reg_we_o, bus.jump_flag_o, bus.busy_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000",
                        {bus.ready_o, bus.reg_we_o, bus.jump_flag_o, bus.busy_o});
    end
    tests++;
    if ({bus.result_o, bus.reg_waddr_o, bus.jump_addr_o} !== 69'd0) begin
      fails++; $display("FAIL reset_data: got res=%h wa=%h ja=%h want 0",
                        bus.result_o, bus.reg_waddr_o, bus.jump_addr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    run_op(INST_DIVU, 32'd100, 32'd7, 5'd9, 32'h0000_1000);
    tests++; if (r_lat !== 33) begin fails++; $display("FAIL divu_latency: got %0d want 33", r_lat); end
    tests++; if (r_res !== 32'd14) begin fails++; $display("FAIL divu_result: got %h want 0000000e", r_res); end
    tests++; if ({r_we, r_jf} !== 2'b11) begin fails++; $display("FAIL divu_we_jf: got %b want 11", {r_we, r_jf}); end
    tests++; if (r_wa !== 5'd9) begin fails++; $display("FAIL divu_waddr: got %0d want 9", r_wa); end
    tests++; if (r_ja !== 32'h0000_1004) begin fails++; $display("FAIL divu_jaddr: got %h want 00001004", r_ja); end
    tests++; if (r_bs !== 1'b1) begin fails++; $display("FAIL busy_start_cycle: got %b want 1", r_bs); end
    tests++; if (r_ba !== 1'b0) begin fails++; $display("FAIL busy_after_done: got %b want 0", r_ba); end
    tests++; if (r_pul !== 1) begin fails++; $display("FAIL divu_pulses: got %0d want 1", r_pul); end
    tests++;
    if ({bus.ready_o, bus.result_o, bus.jump_addr_o} !== {1'b0, 32'd14, 32'h0000_1004}) begin
      fails++; $display("FAIL divu_hold: got rdy=%b res=%h ja=%h want 0/0000000e/00001004",
                        bus.ready_o, bus.result_o, bus.jump_addr_o);
    end
  endtask

  task automatic test_signed();
    logic [2:0]  ops [5] = '{INST_REM, INST_DIV, INST_DIV, INST_REM, INST_REMU};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd100};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1, 32'd2};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i), 32'h0000_0200);
      tests++;
      if (r_res !== exp[i] || r_lat !== 33) begin
        fails++; $display("FAIL signed_%0d: got res=%h lat=%0d want res=%h lat=33", i, r_res, r_lat, exp[i]);
      end
    end
    tests++;
    if (r_wa !== 5'd4 || r_we !== 1'b1) begin
      fails++; $display("FAIL waddr_x0_row: got wa=%0d we=%b want 4/1", r_wa, r_we);
    end
    run_op(INST_DIVU, 32'd8, 32'd4, 5'd0, 32'h0000_0300);
    tests++;
    if (r_wa !== 5'd0 || r_we !== 1'b1 || r_res !== 32'd2) begin
      fails++; $display("FAIL x0_writeback: got wa=%0d we=%b res=%h want 0/1/00000002", r_wa, r_we, r_res);
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [7] = '{INST_DIV, INST_REM, INST_DIVU, INST_REMU, INST_DIV, INST_REM, INST_DIVU};
    logic [31:0] as  [7] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [7] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
    int          lat [7] = '{SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, 33};
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 5'd12, 32'h0000_0400);
      tests++;
      if (r_res !== exp[i] || r_lat !== lat[i] || r_pul !== 1) begin
        fails++; $display("FAIL special_%0d: got res=%h lat=%0d pulses=%0d want res=%h lat=%0d pulses=1",
                          i, r_res, r_lat, r_pul, exp[i], lat[i]);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = INST_DIVU; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
    bus.reg_waddr_i = 5'd3; bus.inst_addr_i = 32'h0000_0500;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.ready_o, bus.reg_we_o} !== 2'b00) begin
      fails++; $display("FAIL flush_pulse: got %b want 00", {bus.ready_o, bus.reg_we_o});
    end
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy_o); end
    n = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (bus.ready_o || bus.reg_we_o) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL flush_no_ready: got %0d pulses want 0", n); end

    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.dividend_i = 32'd8; bus.divisor_i = 32'd2;
    #1;
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL start_flush_busy: got %b want 0", bus.busy_o); end
    @(posedge clk);
    #1 begin bus.start_i = 1'b0; bus.flush_i = 1'b0; end
    n = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (bus.ready_o || bus.busy_o) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL start_flush_ignored: got %0d active cycles want 0", n); end

    run_op(INST_DIVU, 32'd9, 32'd3, 5'd6, 32'h0000_0600);
    tests++;
    if (r_res !== 32'd3 || r_lat !== 33) begin
      fails++; $display("FAIL after_flush_divu: got res=%h lat=%0d want 00000003/33", r_res, r_lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, n;
    logic [31:0] res1, res2;
    logic bs0, b34;
    lat1 = -1; lat2 = -1; n = 0; res1 = 'x; res2 = 'x; b34 = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = INST_DIVU; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    bus.reg_waddr_i = 5'd3; bus.inst_addr_i = 32'h0000_2000;
    #1 bs0 = bus.busy_o;
    tests++; if (bs0 !== 1'b1) begin fails++; $display("FAIL b2b_busy_comb: got %b want 1", bs0); end
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        n++;
        if (lat1 < 0) begin lat1 = k; res1 = bus.result_o; end
        else if (lat2 < 0) begin lat2 = k; res2 = bus.result_o; end
      end
      if (k == 33) begin bus.dividend_i = 32'd9; bus.divisor_i = 32'd3; end
      if (k == 34) b34 = bus.busy_o;
      if (k == 35) bus.start_i = 1'b0;
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", n); end
    tests++;
    if (lat1 !== 33 || res1 !== 32'd14) begin
      fails++; $display("FAIL b2b_first: got lat=%0d res=%h want 33/0000000e", lat1, res1);
    end
    tests++;
    if (lat2 !== 67 || res2 !== 32'd3) begin
      fails++; $display("FAIL b2b_second: got lat=%0d res=%h want 67/00000003", lat2, res2);
    end
    tests++; if (b34 !== 1'b1) begin fails++; $display("FAIL b2b_idle_accept_busy: got %b want 1", b34); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = INST_DIVU; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    bus.reg_waddr_i = 5'd7; bus.inst_addr_i = 32'h0000_3000;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.busy_o, bus.ready_o, bus.reg_we_o, bus.jump_flag_o} !== 4'b0000 ||
        {bus.result_o, bus.reg_waddr_o, bus.jump_addr_o} !== 69'd0) begin
      fails++; $display("FAIL reset_mid_outputs: got busy=%b rdy=%b res=%h wa=%h ja=%h want all 0",
                        bus.busy_o, bus.ready_o, bus.result_o, bus.reg_waddr_o, bus.jump_addr_o);
    end
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (bus.ready_o || bus.reg_we_o) n++; end
    tests++; if (n !== 0) begin fails++; $display("FAIL reset_mid_no_wb: got %0d pulses want 0", n); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.reg_waddr_i = '0; bus.inst_addr_i = '0; bus.flush_i = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
